// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO write access.
// Latency: WIDTH+1 cycles from request to the done pulse; HI/LO update on the edge into DONE.
// Backpressure: stallE holds fetch/decode/execute from the request cycle until the last iteration.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   startE, opE          request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   srcaE, srcbE         multiplicand/dividend and multiplier/divisor (post-forwarding)
//   flushE               cancels an accepted or in-flight operation
//   hiwrite, lowrite     MTHI/MTLO write enables, with wdata
//   stallE, busy, done   pipeline hold, operation in flight, one-cycle completion pulse
//   hi, lo               HI/LO registers for MFHI/MFLO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic [WIDTH-1:0] wdata,
  output logic             stallE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // |multiplicand| for MUL, |divisor| for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   rem_q, rem_d;       // settled remainder, always < divisor
  logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shift out the top, quotient bits in
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // raw dividend, returned in HI on divide by zero
  logic               neg_q, neg_d;       // negate product / quotient
  logic               neg_r_q, neg_r_d;   // negate remainder (dividend sign)
  logic               dz_q, dz_d;         // divide by zero

  // Operand preprocessing: only signed ops (opE[0]=0) take absolute values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = srcaE[WIDTH-1] & ~opE[0];
  assign b_neg = srcbE[WIDTH-1] & ~opE[0];
  assign a_abs = a_neg ? -srcaE : srcaE;
  assign b_abs = b_neg ? -srcbE : srcbE;

  // One shift-add multiply step: add multiplicand if the low multiplier bit is set, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = neg_q ? -mul_next : mul_next;

  // One restoring divide step on a WIDTH+1 bit partial remainder. The top bit of the
  // difference is the borrow: clear means the trial subtraction fits.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], div_ge};
  // Most-negative / -1 needs no special case: |a| = 2^(W-1) unsigned, quotient is the same
  // bit pattern with no negation (signs equal), and the remainder is zero.
  assign quo_res   = neg_q ? -quo_next : quo_next;
  assign rem_res   = neg_r_q ? -rem_next : rem_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    a_raw_d = a_raw_q;
    neg_d   = neg_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // MTHI/MTLO only land while no iteration is running.
        if (hiwrite) hi_d = wdata;
        if (lowrite) lo_d = wdata;
        if (state_q == S_DONE) begin
          // A request presented here is re-issued by the pipeline once stall drops.
          state_d = S_IDLE;
        end else if (startE && !flushE) begin
          cnt_d   = CW'(WIDTH);
          a_raw_d = srcaE;
          neg_d   = a_neg ^ b_neg;
          neg_r_d = a_neg;
          dz_d    = opE[1] && (srcbE == '0);
          rem_d   = '0;
          if (opE[1]) begin
            state_d = S_DIV;
            mcand_d = b_abs;
            quo_d   = a_abs;
          end else begin
            state_d = S_MUL;
            mcand_d = a_abs;
            acc_d   = {{WIDTH{1'b0}}, b_abs};
          end
        end
      end

      S_MUL: begin
        if (flushE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            hi_d    = mul_res[2*WIDTH-1:WIDTH];
            lo_d    = mul_res[WIDTH-1:0];
          end
        end
      end

      default: begin  // S_DIV
        if (flushE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            if (dz_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_res;
              lo_d = quo_res;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      a_raw_q <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      a_raw_q <= a_raw_d;
      neg_q   <= neg_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign stallE = ((state_q == S_IDLE) && startE && !flushE) || busy;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against a model,
// and hand-written flush / reset / ignored-request / WIDTH=8 sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE, flushE, hiwrite, lowrite;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE, wdata;
  logic        stallE, busy, done;
  logic [31:0] hi, lo;

  logic        s8_start, s8_flush, s8_hiw, s8_low;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_wdata;
  logic        s8_stall, s8_busy, s8_done;
  logic [7:0]  s8_hi, s8_lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .flushE(flushE), .hiwrite(hiwrite), .lowrite(lowrite), .wdata(wdata),
    .stallE(stallE), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .startE(s8_start), .opE(s8_op), .srcaE(s8_a), .srcbE(s8_b),
    .flushE(s8_flush), .hiwrite(s8_hiw), .lowrite(s8_low), .wdata(s8_wdata),
    .stallE(s8_stall), .busy(s8_busy), .done(s8_done), .hi(s8_hi), .lo(s8_lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: full-precision arithmetic straight from the instruction definitions.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    int          sa, sb;
    longint      sp;
    logic [63:0] p;
    sa = a;
    sb = b;
    eh = '0;
    el = '0;
    case (op)
      2'd0: begin sp = longint'(sa) * longint'(sb); p = sp; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (b == 0) begin eh = a; el = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eh = '0; el = 32'h8000_0000; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  // Issues one request with startE held (as a stalled pipeline would) until done, then drops it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int stall_n, output int done_at);
    @(negedge clk);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    stall_n = 0; done_at = -1; rh = 'x; rl = 'x;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stallE) stall_n++;
      if (done) begin
        done_at = c; rh = hi; rl = lo;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    startE = 1'b0;
    #1;
    chk("busy_after_done", {63'b0, busy}, 64'd0);
    chk("done_one_cycle", {63'b0, done}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] rh, rl, eh, el, a, b;
    logic [1:0]  op;
    int          sn, da;

    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[7] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[8] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    tbl[9] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

    rst = 1'b1;
    startE = 0; flushE = 0; hiwrite = 0; lowrite = 0; opE = 0; srcaE = 0; srcbE = 0; wdata = 0;
    s8_start = 0; s8_flush = 0; s8_hiw = 0; s8_low = 0; s8_op = 0; s8_a = 0; s8_b = 0; s8_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_stall", {63'b0, stallE}, 64'd0);
    chk("reset_lo8", {56'b0, s8_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, sn, da);
      chk($sformatf("vec%0d_hi", i), {32'b0, rh}, {32'b0, tbl[i].eh});
      chk($sformatf("vec%0d_lo", i), {32'b0, rl}, {32'b0, tbl[i].el});
      chk($sformatf("vec%0d_done_cycle", i), 64'(da), 64'd33);
      chk($sformatf("vec%0d_stall_cycles", i), 64'(sn), 64'd33);
    end

    // Random operations with a mix of operand classes.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 40) - 20; end
        2: begin a = $urandom; b = 32'h0; end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : $urandom;
          b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_0001;
        end
      endcase
      model(op, a, b, eh, el);
      run_op(op, a, b, rh, rl, sn, da);
      chk($sformatf("rnd%0d_op%0d_hi", i, op), {32'b0, rh}, {32'b0, eh});
      chk($sformatf("rnd%0d_op%0d_lo", i, op), {32'b0, rl}, {32'b0, el});
      chk($sformatf("rnd%0d_done_cycle", i), 64'(da), 64'd33);
      chk($sformatf("rnd%0d_stall_cycles", i), 64'(sn), 64'd33);
    end

    // MTHI, then flush a DIVU in its tenth cycle; a new request right after must be taken.
    @(negedge clk);
    hiwrite = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hiwrite = 1'b0;
    startE = 1'b1; opE = 2'd3; srcaE = 32'd100; srcbE = 32'd7;   // cycle 0
    @(negedge clk);
    startE = 1'b0;                                                // cycle 1
    repeat (9) @(negedge clk);
    flushE = 1'b1;                                                // cycle 10
    #1;
    chk("flush_cyc10_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    flushE = 1'b0;                                                // cycle 11
    #1;
    chk("flush_idle_busy", {63'b0, busy}, 64'd0);
    chk("flush_no_done", {63'b0, done}, 64'd0);
    chk("flush_hi_kept", {32'b0, hi}, 64'h1234);
    startE = 1'b1; opE = 2'd1; srcaE = 32'd3; srcbE = 32'd4;
    #1;
    chk("restart_stall", {63'b0, stallE}, 64'd1);
    @(negedge clk);
    startE = 1'b0;
    #1;
    chk("restart_accepted", {63'b0, busy}, 64'd1);
    da = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (done) begin da = c; break; end
    end
    chk("restart_done_seen", {63'b0, da >= 0}, 64'd1);
    chk("restart_lo", {32'b0, lo}, 64'd12);
    chk("restart_hi", {32'b0, hi}, 64'd0);

    // flushE together with startE in IDLE: not accepted.
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; opE = 2'd1; srcaE = 32'd5; srcbE = 32'd5;
    #1;
    chk("flushstart_stall", {63'b0, stallE}, 64'd0);
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    #1;
    chk("flushstart_busy", {63'b0, busy}, 64'd0);

    // A different request presented during busy is ignored.
    @(negedge clk);
    startE = 1'b1; opE = 2'd1; srcaE = 32'd6; srcbE = 32'd7;
    da = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) begin opE = 2'd3; srcaE = 32'd100; srcbE = 32'd3; end
      #1;
      if (done) begin da = c; break; end
    end
    chk("ignore_done_seen", {63'b0, da >= 0}, 64'd1);
    chk("ignore_lo", {32'b0, lo}, 64'd42);
    chk("ignore_hi", {32'b0, hi}, 64'd0);
    @(negedge clk);
    startE = 1'b0;
    #1;
    chk("ignore_idle", {63'b0, busy}, 64'd0);

    // Reset in cycle 5 of a MULT clears everything at once.
    @(negedge clk);
    startE = 1'b1; opE = 2'd0; srcaE = 32'hFFFF_FFFD; srcbE = 32'd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      startE = 1'b0;
    end
    #1;
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_stays_idle_lo", {32'b0, lo}, 64'd0);

    // WIDTH=8: MULTU 200*200, then MTLO in the DONE cycle.
    @(negedge clk);
    s8_start = 1'b1; s8_op = 2'd1; s8_a = 8'd200; s8_b = 8'd200;
    sn = 0; da = -1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s8_stall) sn++;
      if (c == 1) s8_start = 1'b0;
      if (s8_done) begin da = c; break; end
      @(negedge clk);
    end
    chk("w8_done_cycle", 64'(da), 64'd9);
    chk("w8_stall_cycles", 64'(sn), 64'd9);
    chk("w8_product", {48'b0, s8_hi, s8_lo}, 64'h9C40);
    s8_low = 1'b1; s8_wdata = 8'h55;
    @(negedge clk);
    s8_low = 1'b0;
    #1;
    chk("w8_mtlo_in_done", {56'b0, s8_lo}, 64'h55);
    chk("w8_hi_kept", {56'b0, s8_hi}, 64'h9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
